// File: rtl/sb_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// sb_pkg : state type and LFSR constants for sb_trial_sequencer
// Rev 1.0
//----------------------------------------------------------------------
package sb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_INIT  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_EVAL  = 3'd5,
    ST_DONE  = 3'd6
  } sb_state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_lfsr32.sv
`default_nettype none
//----------------------------------------------------------------------
// sb_lfsr32 : 32-bit Galois LFSR with seed load and advance
// Rev 1.0
//----------------------------------------------------------------------
module sb_lfsr32
  import sb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        adv_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // A zero seed would lock the register up, so it is replaced.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 32'h0) ? LFSR_SEED : seed_i;
    end else if (adv_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/sb_trial_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------
// sb_trial_sequencer : runs repeated GbSB trials and keeps the best result
// Rev 1.0
//----------------------------------------------------------------------
module sb_trial_sequencer
  import sb_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [15:0]                      cfg_trials,
  input  logic [31:0]                      cfg_steps,
  input  logic [31:0]                      cfg_seed,
  input  logic                             abort,
  output logic                             core_init_valid,
  output logic                             core_start,
  output logic [31:0]                      core_M,
  output logic [N-1:0][DATA_WIDTH-1:0]     core_x0,
  output logic [N-1:0][DATA_WIDTH-1:0]     core_y0,
  output logic [N-1:0][DATA_WIDTH-1:0]     core_p0,
  input  logic                             core_done,
  input  logic [DATA_WIDTH-1:0]            core_energy,
  input  logic [N-1:0]                     core_spins,
  output logic                             busy,
  output logic                             job_done,
  output logic                             aborted,
  output logic [DATA_WIDTH-1:0]            best_energy,
  output logic [N-1:0]                     best_spins,
  output logic [15:0]                      best_trial,
  output logic [15:0]                      trials_run
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = FRAC_WIDTH - 4;

  sb_state_e                       state_q, state_d;
  logic [KW-1:0]                   seed_idx_q;
  logic [15:0]                     count_q;
  logic [31:0]                     steps_q;
  logic                            done_prev_q;
  logic [DATA_WIDTH-1:0]           energy_q;
  logic [N-1:0]                    spins_q;
  logic [15:0]                     trials_run_q;
  logic [DATA_WIDTH-1:0]           best_energy_q;
  logic [N-1:0]                    best_spins_q;
  logic [15:0]                     best_trial_q;
  logic                            aborted_q;
  logic                            busy_q;
  logic [N-1:0][DATA_WIDTH-1:0]    x0_q;

  logic [31:0]                     lfsr_state;
  logic [31:0]                     w_lfsr_next;
  logic signed [31:0]              w_x32;
  logic [DATA_WIDTH-1:0]           w_x0;
  logic                            w_accept, w_active, w_abort, w_rise;
  logic                            w_last_seed, w_last_trial, w_eval, w_better;

  sb_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_accept),
    .seed_i  (cfg_seed),
    .adv_i   (state_q == ST_SEED),
    .state_o (lfsr_state)
  );

  // Low XW bits of the freshly advanced LFSR, sign-extended: [-1/32, 1/32).
  assign w_lfsr_next = lfsr_step(lfsr_state);
  assign w_x32       = $signed(w_lfsr_next << (32 - XW)) >>> (32 - XW);
  assign w_x0        = DATA_WIDTH'(w_x32);

  assign w_accept     = cfg_valid && (state_q == ST_IDLE);
  assign w_active     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign w_abort      = abort && w_active;
  assign w_rise       = core_done && !done_prev_q;
  assign w_last_seed  = (seed_idx_q == KW'(N - 1));
  assign w_last_trial = (trials_run_q == (count_q - 16'd1));
  assign w_eval       = (state_q == ST_EVAL) && !abort;
  assign w_better     = (trials_run_q == 16'd0) ||
                        ($signed(energy_q) < $signed(best_energy_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_valid) state_d = ST_SEED;
      ST_SEED:  if (w_last_seed) state_d = ST_INIT;
      ST_INIT:  state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (w_rise) state_d = ST_EVAL;
      ST_EVAL:  state_d = w_last_trial ? ST_DONE : ST_SEED;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (w_abort) state_d = ST_DONE;
  end

  always_comb begin
    cfg_ready       = (state_q == ST_IDLE);
    core_init_valid = (state_q == ST_INIT);
    core_start      = (state_q == ST_START);
    job_done        = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_idx_q    <= '0;
      count_q       <= '0;
      steps_q       <= '0;
      done_prev_q   <= 1'b0;
      energy_q      <= '0;
      spins_q       <= '0;
      trials_run_q  <= '0;
      best_energy_q <= '0;
      best_spins_q  <= '0;
      best_trial_q  <= '0;
      aborted_q     <= 1'b0;
      busy_q        <= 1'b0;
      x0_q          <= '0;
    end else begin
      done_prev_q <= core_done;
      if (state_q == ST_SEED) begin
        x0_q[seed_idx_q] <= w_x0;
        seed_idx_q       <= w_last_seed ? '0 : seed_idx_q + 1'b1;
      end else begin
        seed_idx_q <= '0;
      end
      if (w_accept) begin
        count_q      <= (cfg_trials == 16'd0) ? 16'd1 : cfg_trials;
        steps_q      <= cfg_steps;
        trials_run_q <= '0;
        best_trial_q <= '0;
        aborted_q    <= 1'b0;
        busy_q       <= 1'b1;
      end
      if (w_abort) aborted_q <= 1'b1;
      if (state_q == ST_DONE) busy_q <= 1'b0;
      if ((state_q == ST_RUN) && w_rise) begin
        energy_q <= core_energy;
        spins_q  <= core_spins;
      end
      // Strict compare keeps the earlier trial on a tie.
      if (w_eval) begin
        trials_run_q <= trials_run_q + 16'd1;
        if (w_better) begin
          best_energy_q <= energy_q;
          best_spins_q  <= spins_q;
          best_trial_q  <= trials_run_q;
        end
      end
    end
  end

  assign core_M      = steps_q;
  assign core_x0     = x0_q;
  assign core_y0     = '0;
  assign core_p0     = '0;
  assign busy        = busy_q;
  assign aborted     = aborted_q;
  assign best_energy = best_energy_q;
  assign best_spins  = best_spins_q;
  assign best_trial  = best_trial_q;
  assign trials_run  = trials_run_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_trial_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------
// tb_sb_trial_sequencer : directed + randomized bench with a job-level model
// Rev 1.0
//----------------------------------------------------------------------
module tb_sb_trial_sequencer;

  localparam int N  = 8;
  localparam int DW = 32;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      cfg_valid = 1'b0;
  logic [15:0]               cfg_trials = '0;
  logic [31:0]               cfg_steps = '0;
  logic [31:0]               cfg_seed = '0;
  logic                      abort = 1'b0;
  logic                      core_done = 1'b0;
  logic [DW-1:0]             core_energy = '0;
  logic [N-1:0]              core_spins = '0;
  logic                      cfg_ready, core_init_valid, core_start;
  logic [31:0]               core_M;
  logic [N-1:0][DW-1:0]      core_x0, core_y0, core_p0;
  logic                      busy, job_done, aborted;
  logic [DW-1:0]             best_energy;
  logic [N-1:0]              best_spins;
  logic [15:0]               best_trial, trials_run;

  always #5 clk = ~clk;

  sb_trial_sequencer #(.N(N), .DATA_WIDTH(DW), .FRAC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_trials(cfg_trials), .cfg_steps(cfg_steps), .cfg_seed(cfg_seed),
    .abort(abort), .core_init_valid(core_init_valid), .core_start(core_start),
    .core_M(core_M), .core_x0(core_x0), .core_y0(core_y0), .core_p0(core_p0),
    .core_done(core_done), .core_energy(core_energy), .core_spins(core_spins),
    .busy(busy), .job_done(job_done), .aborted(aborted),
    .best_energy(best_energy), .best_spins(best_spins),
    .best_trial(best_trial), .trials_run(trials_run)
  );

  int checks = 0;
  int errors = 0;
  int jd_cnt = 0;
  int cs_cnt = 0;
  int jd0 = 0;
  int cs0 = 0;

  always @(posedge clk) begin
    if (job_done === 1'b1) jd_cnt <= jd_cnt + 1;
    if (core_start === 1'b1) cs_cnt <= cs_cnt + 1;
  end

  // Job-level reference model
  logic [31:0]  m_lfsr;
  logic [31:0]  m_steps;
  logic [31:0]  m_best;
  logic [N-1:0] m_best_spins;
  int           m_best_trial;
  int           m_count;
  int           m_trials;

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int trials, input logic [31:0] steps,
                           input logic [31:0] seed, input bit with_abort);
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid  = 1'b1;
    cfg_trials = trials[15:0];
    cfg_steps  = steps;
    cfg_seed   = seed;
    abort      = with_abort;
    @(negedge clk);
    cfg_valid = 1'b0;
    abort     = 1'b0;
    check("busy_after_accept", busy, 1);
    check("cfg_ready_busy", cfg_ready, 0);
    check("trials_run_clear", trials_run, 0);
    check("best_trial_clear", best_trial, 0);
    check("aborted_clear", aborted, 0);
    m_lfsr   = (seed == 32'h0) ? 32'h1 : seed;
    m_count  = (trials == 0) ? 1 : trials;
    m_trials = 0;
    m_steps  = steps;
    jd0      = jd_cnt;
    cs0      = cs_cnt;
  endtask

  task automatic do_trial(input logic [31:0] energy, input logic [N-1:0] spins,
                          input int lat, input bit held);
    int t;
    logic signed [11:0] lo;
    logic signed [31:0] ext;
    logic [31:0] xe;
    t = 0;
    while (core_init_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("init_valid_seen", core_init_valid, 1);
    for (int k = 0; k < N; k++) begin
      m_lfsr = m_step(m_lfsr);
      lo  = m_lfsr[11:0];
      ext = lo;
      xe  = ext;
      check("core_x0", core_x0[k], xe);
      check("core_y0_p0_zero", {core_y0[k], core_p0[k]}, 0);
    end
    @(negedge clk);
    check("init_valid_pulse", core_init_valid, 0);
    check("core_start", core_start, 1);
    check("core_M", core_M, m_steps);
    @(negedge clk);
    check("core_start_pulse", core_start, 0);
    repeat (lat) @(negedge clk);
    if (held) begin
      check("held_no_eval", trials_run, m_trials);
      check("held_no_done", job_done, 0);
      core_done = 1'b0;
      @(negedge clk);
    end
    core_done   = 1'b1;
    core_energy = energy;
    core_spins  = spins;
    @(negedge clk);
    core_done = 1'b0;
    if (m_trials == 0 || $signed(energy) < $signed(m_best)) begin
      m_best       = energy;
      m_best_spins = spins;
      m_best_trial = m_trials;
    end
    m_trials++;
    @(negedge clk);
    check("trials_run", trials_run, m_trials);
    check("best_energy", best_energy, m_best);
    check("best_spins", best_spins, m_best_spins);
    check("best_trial", best_trial, m_best_trial);
  endtask

  task automatic finish_job(input bit exp_aborted);
    int t;
    t = 0;
    while (job_done !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("job_done_seen", job_done, 1);
    check("aborted_flag", aborted, exp_aborted);
    check("busy_in_done", busy, 1);
    check("trials_run_final", trials_run, m_trials);
    @(negedge clk);
    check("job_done_pulse", job_done, 0);
    check("busy_released", busy, 0);
    check("cfg_ready_back", cfg_ready, 1);
    check("job_done_count", jd_cnt - jd0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int ev;
    int ntr;
    logic [31:0] en;
    int jd_snap;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_job_done", job_done, 0);
    check("rst_init_valid", core_init_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_outputs_zero", {aborted, best_energy, best_trial, trials_run, core_M}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_init_valid", core_init_valid, 0);
    check("post_rst_core_start", core_start, 0);

    // Abort in IDLE is ignored
    jd_snap = jd_cnt;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", cfg_ready, 1);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_flag", aborted, 0);
    check("idle_abort_no_done", jd_cnt - jd_snap, 0);

    // Three trials, energies -5, -9, -9 (tie keeps trial 1)
    start_job(3, 32'd50, 32'd1, 1'b0);
    do_trial(-32'sd5, 8'h11, 3, 1'b0);
    do_trial(-32'sd9, 8'h22, 5, 1'b0);
    do_trial(-32'sd9, 8'h33, 2, 1'b0);
    finish_job(1'b0);
    check("dir_best_energy", best_energy, 32'hFFFF_FFF7);
    check("dir_best_trial", best_trial, 1);
    check("dir_trials_run", trials_run, 3);
    check("dir_starts", cs_cnt - cs0, 3);

    // Zero trials runs exactly one; zero seed behaves like seed 1; abort with cfg_valid ignored
    start_job(0, 32'd7, 32'd0, 1'b1);
    do_trial(32'd4, 8'hA5, 2, 1'b0);
    finish_job(1'b0);
    check("zero_trials_run", trials_run, 1);
    check("zero_trials_starts", cs_cnt - cs0, 1);

    // Abort 4 cycles into RUN of the second trial
    start_job(5, 32'd100, 32'hDEAD_BEEF, 1'b0);
    do_trial(32'd12, 8'h0F, 2, 1'b0);
    t = 0;
    while (core_start !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("abort_start_seen", core_start, 1);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    t = 0;
    while (job_done !== 1'b1 && t < 2) begin
      @(negedge clk);
      t++;
    end
    check("abort_done_latency", job_done, 1);
    finish_job(1'b1);
    check("abort_best_kept", best_energy, 32'd12);
    check("abort_starts", cs_cnt - cs0, 2);

    // core_done held high across job start
    core_done = 1'b1;
    repeat (2) @(negedge clk);
    start_job(1, 32'd9, 32'h1234_5678, 1'b0);
    do_trial(-32'sd3, 8'h5A, 4, 1'b1);
    finish_job(1'b0);

    // Reset mid-RUN
    start_job(3, 32'd40, $urandom, 1'b0);
    t = 0;
    while (core_start !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    jd_snap = jd_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_cfg_ready", cfg_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_trials_run", trials_run, 0);
    check("midrst_best_energy", best_energy, 0);
    @(negedge clk);
    check("midrst_core_start", core_start, 0);
    repeat (4) @(negedge clk);
    check("midrst_no_job_done", jd_cnt - jd_snap, 0);

    // Randomized jobs
    for (int j = 0; j < 5; j++) begin
      ntr = int'($urandom_range(1, 4));
      start_job(ntr, $urandom, $urandom, 1'b0);
      for (int i = 0; i < ntr; i++) begin
        ev = int'($urandom_range(0, 16)) - 8;
        en = ev;
        do_trial(en, N'($urandom), int'($urandom_range(1, 6)), 1'b0);
      end
      finish_job(1'b0);
      check("rand_starts", cs_cnt - cs0, ntr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
